// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver.
// The PARITY state is present only when UART_RX_PARITY_EN is defined.
package uart_pkg;

    localparam int unsigned DEFAULT_CLKS_PER_BIT = 10416;
    localparam int unsigned UART_DATA_W          = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; both flops reset high (idle level).
module uart_rx_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic rx_i,
    output logic rxs_o
);

    logic meta;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta  <= 1'b1;
            rxs_o <= 1'b1;
        end else begin
            meta  <= rx_i;
            rxs_o <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1 by default; 8E1 with even-parity check when UART_RX_PARITY_EN is defined.
// All frame logic runs on the synchronized line; outputs are registered one-cycle strobes.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   rx_i,
    output logic [UART_DATA_W-1:0] data_o,
    output logic                   valid_o,
    output logic                   frame_err_o,
    output logic                   parity_err_o,
    output logic                   busy_o
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

    rx_state_t              state, state_n;
    logic [CW-1:0]          cnt, cnt_n;
    logic [2:0]             bit_idx, bit_idx_n;
    logic [UART_DATA_W-1:0] shift, shift_n;
    logic [UART_DATA_W-1:0] data_n;
    logic                   valid_n, ferr_n, perr_n;
    logic                   rxs, rxs_d;
`ifdef UART_RX_PARITY_EN
    logic                   par_bit, par_bit_n;
`endif

    uart_rx_sync u_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .rx_i  (rx_i),
        .rxs_o (rxs)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= IDLE;
            cnt          <= '0;
            bit_idx      <= '0;
            shift        <= '0;
            rxs_d        <= 1'b1;
            data_o       <= '0;
            valid_o      <= 1'b0;
            frame_err_o  <= 1'b0;
            parity_err_o <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit      <= 1'b0;
`endif
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            bit_idx      <= bit_idx_n;
            shift        <= shift_n;
            rxs_d        <= rxs;
            data_o       <= data_n;
            valid_o      <= valid_n;
            frame_err_o  <= ferr_n;
            parity_err_o <= perr_n;
`ifdef UART_RX_PARITY_EN
            par_bit      <= par_bit_n;
`endif
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_idx_n = bit_idx;
        shift_n   = shift;
        data_n    = data_o;
        valid_n   = 1'b0;
        ferr_n    = 1'b0;
        perr_n    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bit_n = par_bit;
`endif
        unique case (state)
            IDLE: begin
                cnt_n = '0;
                // Requires a real falling edge, so a held-low line cannot re-arm
                if (rxs_d && !rxs) state_n = START;
            end
            START: begin
                if (cnt == HALF_LAST) begin
                    cnt_n = '0;
                    if (rxs) begin
                        state_n = IDLE;
                    end else begin
                        bit_idx_n = '0;
                        state_n   = DATA;
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_n     = '0;
                    shift_n   = {rxs, shift[UART_DATA_W-1:1]};
                    bit_idx_n = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt == BIT_LAST) begin
                    cnt_n     = '0;
                    par_bit_n = rxs;
                    state_n   = STOP;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
`endif
            STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_n   = '0;
                    state_n = IDLE;
`ifdef UART_RX_PARITY_EN
                    perr_n = (^shift) != par_bit;
`endif
                    if (rxs && !perr_n) begin
                        valid_n = 1'b1;
                        data_n  = shift;
                    end else begin
                        ferr_n = !rxs;
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign busy_o = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx at CLKS_PER_BIT=16.
// Define UART_RX_PARITY_EN for both DUT and bench to exercise the 8E1 build.
module tb_uart_rx;

    localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] data;
    logic       valid, ferr, perr, busy;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int vcnt = 0, fcnt = 0, pcnt = 0;
    int         vtime[$];
    logic [7:0] vdata[$];

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .rx_i         (rx),
        .data_o       (data),
        .valid_o      (valid),
        .frame_err_o  (ferr),
        .parity_err_o (perr),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid) begin
            vcnt++;
            vtime.push_back(cyc);
            vdata.push_back(data);
        end
        if (ferr) fcnt++;
        if (perr) pcnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        vcnt = 0; fcnt = 0; pcnt = 0;
        vtime.delete();
        vdata.delete();
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_flip);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(CPB);
        end
`ifdef UART_RX_PARITY_EN
        rx = (^b) ^ par_flip;
        tick(CPB);
`endif
        rx = stop_bit;
        tick(CPB);
    endtask

    initial begin
        logic [7:0] frame_bits;
        int gap;
        bit done;

        tick(5);
        check("rst_data",  32'(data),  32'h0);
        check("rst_valid", 32'(valid), 32'h0);
        check("rst_ferr",  32'(ferr),  32'h0);
        check("rst_perr",  32'(perr),  32'h0);
        check("rst_busy",  32'(busy),  32'h0);
        rst = 1'b0;
        tick(CPB);

        // Basic good frame
        clear_mon();
        send_frame(8'h55, 1'b1, 1'b0);
        tick(4);
        check("x55_vcnt", 32'(vcnt), 32'd1);
        check("x55_data", 32'(data), 32'h55);
        check("x55_ferr", 32'(fcnt), 32'd0);

        // Short low glitch is a false start
        clear_mon();
        rx = 1'b0;
        tick(4);
        rx = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 10 && !done; i++) begin
            tick(1);
            if (!busy) done = 1'b1;
        end
        check("glitch_busy", 32'(busy), 32'h0);
        tick(CPB);
        check("glitch_vcnt", 32'(vcnt), 32'd0);
        check("glitch_ferr", 32'(fcnt), 32'd0);

        // Framing error followed by a break
        send_frame(8'h11, 1'b1, 1'b0);
        tick(4);
        check("x11_data", 32'(data), 32'h11);
        clear_mon();
        send_frame(8'hA3, 1'b0, 1'b0);
        rx = 1'b0;
        tick(100);
        check("ferr_cnt",   32'(fcnt), 32'd1);
        check("ferr_vcnt",  32'(vcnt), 32'd0);
        check("ferr_data",  32'(data), 32'h11);
        check("break_busy", 32'(busy), 32'h0);
        rx = 1'b1;
        tick(2 * CPB);
        check("break_ferr", 32'(fcnt), 32'd1);
        check("break_vcnt", 32'(vcnt), 32'd0);

        // Back-to-back frames without idle gap
        clear_mon();
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        tick(4);
        check("b2b_vcnt", 32'(vcnt), 32'd2);
        if (vcnt == 2) begin
            check("b2b_d0", 32'(vdata[0]), 32'h00);
            check("b2b_d1", 32'(vdata[1]), 32'hFF);
            gap = vtime[1] - vtime[0];
            check("b2b_gap", (gap >= FRAME_BITS*CPB-1 && gap <= FRAME_BITS*CPB+1) ? 32'(FRAME_BITS*CPB) : 32'(gap),
                  32'(FRAME_BITS*CPB));
        end
        check("b2b_ferr", 32'(fcnt), 32'd0);

        // Reset during data bit 3 of an aborted 0x3C frame
        clear_mon();
        frame_bits = 8'h3C;
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 3; i++) begin
            rx = frame_bits[i];
            tick(CPB);
        end
        rx = frame_bits[3];
        tick(CPB / 2);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("mrst_data",  32'(data),  32'h0);
        check("mrst_valid", 32'(valid), 32'h0);
        check("mrst_ferr",  32'(ferr),  32'h0);
        check("mrst_perr",  32'(perr),  32'h0);
        check("mrst_busy",  32'(busy),  32'h0);
        rx = 1'b1;
        tick(8 * CPB);
        check("mrst_vcnt", 32'(vcnt), 32'd0);
        check("mrst_fcnt", 32'(fcnt), 32'd0);
        send_frame(8'h3C, 1'b1, 1'b0);
        tick(4);
        check("x3c_vcnt", 32'(vcnt), 32'd1);
        check("x3c_data", 32'(data), 32'h3C);
        check("x3c_ferr", 32'(fcnt), 32'd0);

`ifdef UART_RX_PARITY_EN
        // 0x07 has three ones, so the even-parity bit must be 1
        clear_mon();
        send_frame(8'h07, 1'b1, 1'b1);
        tick(4);
        check("par_bad_pcnt", 32'(pcnt), 32'd1);
        check("par_bad_vcnt", 32'(vcnt), 32'd0);
        check("par_bad_data", 32'(data), 32'h3C);
        clear_mon();
        send_frame(8'h07, 1'b1, 1'b0);
        tick(4);
        check("par_ok_vcnt", 32'(vcnt), 32'd1);
        check("par_ok_data", 32'(data), 32'h07);
        check("par_ok_pcnt", 32'(pcnt), 32'd0);
`else
        check("noparity_pcnt", 32'(pcnt), 32'd0);
        check("noparity_perr", 32'(perr), 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
